// File: rtl/bitwise_sched.sv
// bitwise_sched: round-robin scheduler sharing one 3-bit bitwise datapath among NREQ requesters.
// Optional BITWISE_SCHED_STATS_EN adds a 16-bit completed-response counter output done_cnt.
module bitwise_sched #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [3*NREQ-1:0]        req_x,
  input  logic [3*NREQ-1:0]        req_y,
  output logic [NREQ-1:0]          req_ready,
  output logic [2:0]               op_x,
  output logic [2:0]               op_y,
  input  logic                     op_z,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_z,
  input  logic                     rsp_ready,
  output logic                     busy
`ifdef BITWISE_SCHED_STATS_EN
  ,
  output logic [15:0]              done_cnt
`endif
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, RESP} state_t;
  state_t        state_q;
  logic [IW-1:0] ptr_q, id_q, win, idx;
  logic [2:0]    x_q, y_q;
  logic          z_q, act;
  // Descending scan so the closest requester after ptr_q is the last assignment.
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx]) win = idx;
    end
  end
  assign req_ready = (state_q == IDLE && |req_valid) ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
  assign act       = state_q == ISSUE || state_q == SAMPLE;
  assign op_x      = act ? x_q : 3'd0;
  assign op_y      = act ? y_q : 3'd0;
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_z     = rsp_valid & z_q;
  assign busy      = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req_valid) begin
          state_q <= ISSUE;
          ptr_q   <= win;
          id_q    <= win;
          x_q     <= req_x[3*win +: 3];
          y_q     <= req_y[3*win +: 3];
        end
        ISSUE:  state_q <= SAMPLE;
        SAMPLE: begin
          z_q     <= op_z;
          state_q <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
      endcase
    end
  end
`ifdef BITWISE_SCHED_STATS_EN
  logic [15:0] done_cnt_q;
  always_ff @(posedge clk)
    if (rst) done_cnt_q <= '0;
    else if (rsp_valid && rsp_ready) done_cnt_q <= done_cnt_q + 16'd1;
  assign done_cnt = done_cnt_q;
`endif
endmodule

// File: tb/tb_bitwise_sched.sv
// tb_bitwise_sched: directed + random checks of bitwise_sched against a transaction-level model.
module tb_bitwise_sched;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [3*N-1:0] req_x = '0, req_y = '0;
  logic [2:0] op_x, op_y;
  logic op_z, rsp_valid, rsp_z, busy;
  logic rsp_ready = 0;
  logic [1:0] rsp_id;
`ifdef BITWISE_SCHED_STATS_EN
  logic [15:0] done_cnt;
`endif
  int ntest = 0, nfail = 0;
  always #5 clk = ~clk;
  assign op_z = |(op_x & op_y);
  bitwise_sched #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .op_x(op_x), .op_y(op_y), .op_z(op_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
    .busy(busy)
`ifdef BITWISE_SCHED_STATS_EN
    , .done_cnt(done_cnt)
`endif
  );
  // Transaction model: age counts edges since acceptance; operands visible at ages 1-2,
  // response offered from age 3 until consumed.
  bit m_on = 0, m_busy = 0;
  int m_ptr = N - 1, m_age = 0, m_id = 0, m_cnt = 0;
  logic [2:0] m_x = 0, m_y = 0;
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_on = 1; m_busy = 0; m_ptr = N - 1; m_cnt = 0;
    end else if (!m_busy) begin
      if (|req_valid) begin
        m_id = pick(req_valid, m_ptr); m_ptr = m_id; m_busy = 1; m_age = 1;
        m_x = req_x[3*m_id +: 3]; m_y = req_y[3*m_id +: 3];
      end
    end else if (m_age < 3) m_age++;
    else if (rsp_ready) begin
      m_busy = 0; m_cnt = (m_cnt + 1) % 65536;
    end
  end
  initial begin
    logic [N-1:0] er;
    bit eo, ev;
    forever begin
      @(negedge clk);
      if (m_on && !rst) begin
        er = '0;
        if (!m_busy && |req_valid) er[pick(req_valid, m_ptr)] = 1'b1;
        eo = m_busy && (m_age == 1 || m_age == 2);
        ev = m_busy && m_age == 3;
        check("req_ready", req_ready, er);
        check("op_x", op_x, eo ? m_x : 0);
        check("op_y", op_y, eo ? m_y : 0);
        check("rsp_valid", rsp_valid, ev);
        check("rsp_id", rsp_id, ev ? m_id : 0);
        check("rsp_z", rsp_z, ev ? int'(|(m_x & m_y)) : 0);
        check("busy", busy, m_busy);
`ifdef BITWISE_SCHED_STATS_EN
        check("done_cnt", done_cnt, m_cnt);
`endif
      end
    end
  end
  task automatic step(); @(negedge clk); #1; endtask
  task automatic do_reset(); rst = 1; req_valid = '0; step(); step(); rst = 0; endtask
  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
    check("drain_idle", busy, 0);
  endtask
  int g[5], gc[5], ng, hold;
  initial begin
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op_x", op_x, 0);
    // single request
    rsp_ready = 1; req_x[2:0] = 3; req_y[2:0] = 4; req_valid = 4'b0001; #1;
    check("s1_grant", req_ready, 4'b0001);
    step(); req_valid = '0; #1;
    check("s1_issue_x", op_x, 3); check("s1_issue_y", op_y, 4); check("s1_issue_rdy", req_ready, 0);
    step();
    check("s1_sample_x", op_x, 3); check("s1_sample_y", op_y, 4);
    step();
    check("s1_rsp_valid", rsp_valid, 1); check("s1_rsp_id", rsp_id, 0);
    check("s1_rsp_z", rsp_z, 0); check("s1_resp_op_x", op_x, 0);
    step();
    check("s1_done_busy", busy, 0); check("s1_done_valid", rsp_valid, 0);
    // round robin
    do_reset();
    req_x = {N{3'd7}}; req_y = {N{3'd5}}; req_valid = 4'hF; rsp_ready = 1; ng = 0;
    for (int c = 0; c < 24 && ng < 5; c++) begin
      #1;
      if (req_ready != 0) begin g[ng] = $clog2(req_ready); gc[ng] = c; ng++; end
      step();
    end
    req_valid = '0;
    check("rr_count", ng, 5);
    for (int i = 0; i < 5; i++) begin
      check("rr_order", g[i], i % 4);
      check("rr_spacing", gc[i], 4 * i);
    end
    wait_idle();
`ifdef BITWISE_SCHED_STATS_EN
    check("stats_after_rr", done_cnt, 5);
`endif
    // backpressure
    do_reset();
    rsp_ready = 0; req_x[8:6] = 3; req_y[8:6] = 3; req_valid = 4'b0100; hold = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy) check("bp_no_grant", req_ready, 0);
      if (rsp_valid) begin
        hold++;
        check("bp_id", rsp_id, 2); check("bp_z", rsp_z, 1);
        rsp_ready = (hold == 6);
      end else if (hold > 0) begin
        req_valid = '0;
        break;
      end
      step();
    end
    check("bp_hold", hold, 6);
    rsp_ready = 1;
    wait_idle();
    // reset mid-operation
    do_reset();
    req_x[5:3] = 0; req_y[5:3] = 1; req_valid = 4'b0010; #1;
    check("rm_grant", req_ready, 4'b0010);
    step(); req_valid = '0;
    step();
    check("rm_busy_sample", busy, 1);
    rst = 1; step(); rst = 0; #1;
    check("rm_busy_after", busy, 0);
    for (int i = 0; i < 4; i++) begin check("rm_no_rsp", rsp_valid, 0); step(); end
    req_valid = 4'b0011; #1;
    check("rm_next_grant", req_ready, 4'b0001);
    step(); req_valid = '0;
    wait_idle();
    // random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      req_valid = N'($urandom); req_x = (3*N)'($urandom); req_y = (3*N)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; req_valid = '0; rsp_ready = 1;
    step();
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
